// File: rtl/bcd_score_display_pkg.sv
// Shared definitions for the BCD score/display block: active-high 7-segment
// patterns {g,f,e,d,c,b,a}, the digit-count limit and the score operation type.
package bcd_score_display_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_CLR,
        OP_INC,
        OP_DEC
    } score_op_e;

    // Codes 10..15 never occur in a legal score, so they decode to blank.
    function automatic logic [6:0] seg7Encode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_score_display_if.sv
// Score-event and display-pin bundle between the game FSM (master) and the
// score/display block (slave).
interface bcd_score_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    ena;
    logic                    invert;
    logic                    clr;
    logic                    inc;
    logic                    dec;
    logic                    hi_clr;
    logic                    show_hi;
    logic [4*NUM_DIGITS-1:0] score_bcd;
    logic [4*NUM_DIGITS-1:0] hi_bcd;
    logic                    ovf;
    logic                    new_hi;
    logic [6:0]              segments;
    logic [NUM_DIGITS-1:0]   digits;

    modport master (
        output ena, invert, clr, inc, dec, hi_clr, show_hi,
        input  score_bcd, hi_bcd, ovf, new_hi, segments, digits
    );

    modport slave (
        input  ena, invert, clr, inc, dec, hi_clr, show_hi,
        output score_bcd, hi_bcd, ovf, new_hi, segments, digits
    );
endinterface

// File: rtl/bcd_score_display_bcd_counter.sv
// N-digit BCD score register with clear, increment (wrap or saturate) and
// decrement (holds at zero); ovf pulses for an increment at all-9s.
module bcd_counter
    import bcd_score_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    inc_i,
    input  logic                    dec_i,
    output logic [4*NUM_DIGITS-1:0] score_o,
    output logic                    ovf_o
);
    localparam int W = 4 * NUM_DIGITS;

    score_op_e      op;
    logic [W-1:0]   score_q, score_d, incVal, decVal;
    logic           ovf_q, ovf_d;
    logic           carry, borrow;

    always_comb begin
        op = OP_NONE;
        if (clr_i)                op = OP_CLR;
        else if (inc_i && !dec_i) op = OP_INC;
        else if (dec_i && !inc_i) op = OP_DEC;
    end

    // Carry out of the top digit means all-9s; borrow out means the score was 0.
    always_comb begin
        incVal = score_q;
        decVal = score_q;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    incVal[4*i +: 4] = 4'd0;
                end else begin
                    incVal[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (score_q[4*i +: 4] == 4'd0) begin
                    decVal[4*i +: 4] = 4'd9;
                end else begin
                    decVal[4*i +: 4] = score_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        score_d = score_q;
        ovf_d   = 1'b0;
        case (op)
            OP_CLR: score_d = '0;
            OP_INC: begin
                ovf_d = carry;
                if (!(carry && SATURATE)) score_d = incVal;
            end
            OP_DEC: if (!borrow) score_d = decVal;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            score_q <= score_d;
            ovf_q   <= ovf_d;
        end
    end

    assign score_o = score_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/bcd_score_display.sv
// BCD score keeper with high-score tracking and a multiplexed, registered
// 7-segment driver (refresh prescaler, leading-zero blanking, polarity select).
module bcd_score_display
    import bcd_score_display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 16,
    parameter bit BLANK_LEADING = 1'b1,
    parameter bit SATURATE      = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_score_display_if.slave bus
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS || REFRESH_DIV < 1) begin : gBadParams
        $error("bcd_score_display: NUM_DIGITS must be 1..%0d and REFRESH_DIV >= 1", MAX_DIGITS);
    end

    logic [W-1:0]          score, hi_q, hi_d, shown;
    logic                  ovf, new_hi_q, new_hi_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [6:0]            seg_q, seg_d, segRaw;
    logic [NUM_DIGITS-1:0] dig_q, dig_d, digRaw;
    logic [3:0]            digitVal;
    logic                  upperZero, blank;

    bcd_counter #(
        .NUM_DIGITS (NUM_DIGITS),
        .SATURATE   (SATURATE)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (bus.clr),
        .inc_i   (bus.inc),
        .dec_i   (bus.dec),
        .score_o (score),
        .ovf_o   (ovf)
    );

    // Packed BCD compares correctly as plain unsigned binary.
    always_comb begin
        hi_d     = hi_q;
        new_hi_d = 1'b0;
        if (bus.hi_clr) begin
            hi_d = '0;
        end else if (score > hi_q) begin
            hi_d     = score;
            new_hi_d = 1'b1;
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // A digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        shown     = bus.show_hi ? hi_q : score;
        digitVal  = shown[4*idx_q +: 4];
        upperZero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_q) && shown[4*i +: 4] != 4'd0) upperZero = 1'b0;
        end
        blank         = !bus.ena || (BLANK_LEADING && idx_q != '0 && upperZero);
        segRaw        = blank ? SEG_BLANK : seg7Encode(digitVal);
        digRaw        = '0;
        digRaw[idx_q] = 1'b1;
        seg_d         = bus.invert ? ~segRaw : segRaw;
        dig_d         = bus.invert ? ~digRaw : digRaw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            new_hi_q <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            seg_q    <= '0;
            dig_q    <= '0;
        end else begin
            hi_q     <= hi_d;
            new_hi_q <= new_hi_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end

    assign bus.score_bcd = score;
    assign bus.hi_bcd    = hi_q;
    assign bus.ovf       = ovf;
    assign bus.new_hi    = new_hi_q;
    assign bus.segments  = seg_q;
    assign bus.digits    = dig_q;

endmodule

// File: tb/tb_bcd_score_display.sv
// Scoreboard bench for bcd_score_display: 3 digits, 4-cycle refresh, with a
// second saturating instance. Expectations are queued per cycle and popped by a monitor.
module tb_bcd_score_display;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_score_display_if #(.NUM_DIGITS(3)) bus ();
    bcd_score_display_if #(.NUM_DIGITS(3)) satBus ();

    bcd_score_display #(
        .NUM_DIGITS(3), .REFRESH_DIV(4), .BLANK_LEADING(1'b1), .SATURATE(1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    bcd_score_display #(
        .NUM_DIGITS(3), .REFRESH_DIV(4), .BLANK_LEADING(1'b1), .SATURATE(1'b1)
    ) dutSat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (satBus.slave)
    );

    typedef enum int {
        K_SCORE, K_HI, K_OVF, K_NEWHI, K_SEG, K_DIG,
        K_SAT_SCORE, K_SAT_OVF, K_OVF_CNT, K_NEWHI_CNT, K_CLR_CNT
    } kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t       expQ[$];
    exp_t       e;
    int         checks = 0;
    int         failures = 0;
    int         ovfCount = 0;
    int         newHiCount = 0;
    int         releaseCyc;
    int         c0;
    int         t;
    logic [6:0] expSeg [3];
    logic [2:0] expDig [3];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
        checks++;
        if (act !== expVal) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expVal);
        end
    endtask

    task automatic expectAt(input int c, input kind_e k, input logic [31:0] v, input string name);
        exp_t x;
        x.cyc  = c;
        x.kind = k;
        x.val  = v;
        x.name = name;
        expQ.push_back(x);
    endtask

    // Display index seen at cycle m, counted from reset release (4 cycles per digit).
    task automatic expectScan(input int start, input int n);
        for (int m = start; m < start + n; m++) begin
            int idx;
            idx = ((m - releaseCyc - 1) / 4) % 3;
            expectAt(m, K_SEG, 32'(expSeg[idx]), $sformatf("scan_seg_idx%0d", idx));
            expectAt(m, K_DIG, 32'(expDig[idx]), $sformatf("scan_dig_idx%0d", idx));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic i, input logic d, input logic h, input int n);
        bus.clr    = c;
        bus.inc    = i;
        bus.dec    = d;
        bus.hi_clr = h;
        tick(n);
        bus.clr    = 1'b0;
        bus.inc    = 1'b0;
        bus.dec    = 1'b0;
        bus.hi_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ovf)    ovfCount++;
            if (bus.new_hi) newHiCount++;
            while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                e = expQ.pop_front();
                case (e.kind)
                    K_CLR_CNT: begin
                        ovfCount   = 0;
                        newHiCount = 0;
                    end
                    K_SCORE:     checkOutput(e.name, 32'(bus.score_bcd), e.val);
                    K_HI:        checkOutput(e.name, 32'(bus.hi_bcd), e.val);
                    K_OVF:       checkOutput(e.name, 32'(bus.ovf), e.val);
                    K_NEWHI:     checkOutput(e.name, 32'(bus.new_hi), e.val);
                    K_SEG:       checkOutput(e.name, 32'(bus.segments), e.val);
                    K_DIG:       checkOutput(e.name, 32'(bus.digits), e.val);
                    K_SAT_SCORE: checkOutput(e.name, 32'(satBus.score_bcd), e.val);
                    K_SAT_OVF:   checkOutput(e.name, 32'(satBus.ovf), e.val);
                    K_OVF_CNT:   checkOutput(e.name, 32'(ovfCount), e.val);
                    K_NEWHI_CNT: checkOutput(e.name, 32'(newHiCount), e.val);
                    default: ;
                endcase
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        {bus.clr, bus.inc, bus.dec, bus.hi_clr, bus.show_hi, bus.invert} = '0;
        bus.ena = 1'b1;
        {satBus.clr, satBus.inc, satBus.dec, satBus.hi_clr, satBus.show_hi, satBus.invert} = '0;
        satBus.ena = 1'b1;
        tick(3);

        checkOutput("reset_score", 32'(bus.score_bcd), 32'h0);
        checkOutput("reset_hi", 32'(bus.hi_bcd), 32'h0);
        checkOutput("reset_segments", 32'(bus.segments), 32'h0);
        checkOutput("reset_digits", 32'(bus.digits), 32'h0);
        checkOutput("reset_ovf", 32'(bus.ovf), 32'h0);
        checkOutput("reset_new_hi", 32'(bus.new_hi), 32'h0);

        rst_n = 1'b1;
        releaseCyc = cyc;
        expectAt(cyc + 1, K_CLR_CNT, 32'h0, "clear_counts");
        tick(2);

        // 1000 increments: wrap on the non-saturating unit, hold on the saturating one.
        c0 = cyc;
        expectAt(c0 + 1,    K_SCORE,     32'h001, "inc_first");
        expectAt(c0 + 10,   K_SCORE,     32'h010, "inc_carry_tens");
        expectAt(c0 + 100,  K_SCORE,     32'h100, "inc_carry_hundreds");
        expectAt(c0 + 999,  K_SCORE,     32'h999, "score_999");
        expectAt(c0 + 999,  K_OVF,       32'h0,   "ovf_low_at_999");
        expectAt(c0 + 999,  K_SAT_SCORE, 32'h999, "sat_score_999");
        expectAt(c0 + 1000, K_SCORE,     32'h000, "wrap_to_zero");
        expectAt(c0 + 1000, K_OVF,       32'h1,   "ovf_on_wrap");
        expectAt(c0 + 1000, K_HI,        32'h999, "hi_999");
        expectAt(c0 + 1000, K_SAT_SCORE, 32'h999, "sat_hold");
        expectAt(c0 + 1000, K_SAT_OVF,   32'h1,   "sat_ovf_pulse");
        expectAt(c0 + 1001, K_OVF,       32'h0,   "ovf_one_cycle");
        expectAt(c0 + 1001, K_SAT_OVF,   32'h0,   "sat_ovf_one_cycle");
        expectAt(c0 + 1001, K_SAT_SCORE, 32'h999, "sat_still_999");
        expectAt(c0 + 1002, K_OVF_CNT,   32'd1,   "ovf_exactly_once");
        satBus.inc = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1000);
        satBus.inc = 1'b0;
        tick(2);

        t = cyc;
        expectAt(t + 1, K_HI,    32'h0, "hi_clr");
        expectAt(t + 1, K_NEWHI, 32'h0, "hi_clr_no_new_hi");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);

        t = cyc;
        expectAt(t + 1, K_SCORE, 32'h000, "dec_holds_at_zero");
        expectAt(t + 1, K_OVF,   32'h0,   "dec_at_zero_no_ovf");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 41);
        tick(2);

        t = cyc;
        expectAt(t + 1, K_SCORE, 32'h041, "inc_dec_cancel");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1);
        tick(1);

        t = cyc;
        expectAt(t + 1, K_SCORE, 32'h000, "clr_over_inc");
        expectAt(t + 1, K_HI,    32'h041, "hi_kept_on_clr");
        expectAt(t + 2, K_HI,    32'h041, "hi_kept_after_clr");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
        tick(1);

        // Score 007, normal polarity: only the ones digit lights.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7);
        tick(3);
        expSeg = '{7'b0000111, 7'b0000000, 7'b0000000};
        expDig = '{3'b001, 3'b010, 3'b100};
        expectScan(cyc + 1, 13);
        tick(14);

        // Score 105, common-anode: inner zero shown, everything complemented.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 105);
        bus.invert = 1'b1;
        tick(3);
        expSeg = '{7'b0010010, 7'b1000000, 7'b1111001};
        expDig = '{3'b110, 3'b101, 3'b011};
        expectScan(cyc + 1, 13);
        tick(14);

        bus.ena = 1'b0;
        t = cyc;
        expectAt(t + 1, K_SEG,   32'h7F,  "ena_off_blank");
        expectAt(t + 2, K_SEG,   32'h7F,  "ena_off_blank_held");
        expectAt(t + 2, K_SCORE, 32'h106, "count_while_blank");
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
        tick(1);
        bus.ena    = 1'b1;
        bus.invert = 1'b0;

        // High score climbs to 12, then a lower score must not raise it.
        t = cyc;
        expectAt(t + 1, K_CLR_CNT, 32'h0, "clear_counts");
        expectAt(t + 1, K_HI,      32'h0, "hi_clr_with_clr");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1);
        t = cyc;
        expectAt(t + 12, K_SCORE,     32'h012, "score_012");
        expectAt(t + 12, K_HI,        32'h011, "hi_lags_score");
        expectAt(t + 13, K_HI,        32'h012, "hi_012");
        expectAt(t + 13, K_NEWHI,     32'h1,   "new_hi_at_12");
        expectAt(t + 14, K_NEWHI,     32'h0,   "new_hi_one_cycle");
        expectAt(t + 14, K_NEWHI_CNT, 32'd12,  "new_hi_count_rising");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12);
        tick(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3);
        tick(2);
        expectAt(cyc + 1, K_SCORE, 32'h003, "score_003");
        expectAt(cyc + 1, K_HI,    32'h012, "hi_unchanged_by_lower");
        bus.show_hi = 1'b1;
        tick(3);
        expSeg = '{7'b1011011, 7'b0000110, 7'b0000000};
        expDig = '{3'b001, 3'b010, 3'b100};
        expectScan(cyc + 1, 13);
        tick(14);
        expectAt(cyc + 1, K_NEWHI_CNT, 32'd12, "new_hi_count_final");
        tick(2);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_segments", 32'(bus.segments), 32'h0);
        checkOutput("async_rst_digits", 32'(bus.digits), 32'h0);
        checkOutput("async_rst_score", 32'(bus.score_bcd), 32'h0);
        checkOutput("async_rst_hi", 32'(bus.hi_bcd), 32'h0);
        checkOutput("async_rst_new_hi", 32'(bus.new_hi), 32'h0);
        checkOutput("async_rst_sat_score", 32'(satBus.score_bcd), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
